// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

    localparam int         IB_DEPTH_DEFAULT = 8;
    localparam logic [6:0] EXCEPTION_INE    = 7'h0d;
    localparam int         IB_ENTRY_W       = 72;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pc_exc;
        logic [6:0]  pc_exc_cause;
    } ib_entry_t;

    function automatic ib_entry_t ib_entry_gate(input ib_entry_t e, input logic vld);
        return vld ? e : '0;
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push and decode-side pop signals of the instruction buffer.
interface inst_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pc_exc;
    logic [6:0]  in_pc_exc_cause;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pc_exc;
    logic [6:0]  out_pc_exc_cause;
    logic        out_ib_exc;
    logic [6:0]  out_ib_exc_cause;

    modport master (
        output in_valid, in_pc, in_inst, in_pc_exc, in_pc_exc_cause, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_pc_exc, out_pc_exc_cause,
               out_ib_exc, out_ib_exc_cause
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_pc_exc, in_pc_exc_cause, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_pc_exc, out_pc_exc_cause,
               out_ib_exc, out_ib_exc_cause
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode; head visible the cycle after push,
// no bypass. in_ready drops when full; flush empties the queue on the next edge.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter  int DEPTH = IB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    inst_buffer_if.slave   ib,
    output logic [PTR_W:0] count
);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [IB_ENTRY_W-1:0] mem_q [DEPTH];

    logic      push, pop;
    ib_entry_t in_entry, head;

    assign ib.in_ready  = (count_q != (PTR_W+1)'(DEPTH));
    assign ib.out_valid = (count_q != '0);
    assign push         = ib.in_valid  & ib.in_ready  & ~flush;
    assign pop          = ib.out_valid & ib.out_ready & ~flush;

    assign in_entry = '{pc:           ib.in_pc,
                        inst:         ib.in_inst,
                        pc_exc:       ib.in_pc_exc,
                        pc_exc_cause: ib.in_pc_exc_cause};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign head = ib_entry_gate(ib_entry_t'(mem_q[rd_ptr_q]), ib.out_valid);

    assign ib.out_pc           = head.pc;
    assign ib.out_inst         = head.inst;
    assign ib.out_pc_exc       = head.pc_exc;
    assign ib.out_pc_exc_cause = head.pc_exc_cause;
    assign ib.out_ib_exc       = 1'b0;
    assign ib.out_ib_exc_cause = EXCEPTION_INE;
    assign count               = count_q;

endmodule
